alu_pipe: RTL and testbench

//  Parametrised, handshaked successor to the combinational datapath ALU. Takes operands and the

---
 rtl/alu_pipe.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/PSR and iterative shift-add multiplier
//
// Purpose: accepts one operation on a valid/ready input port and holds the registered
// result, write-back flag, illegal flag and PSR until a valid/ready output port consumes them.
// MUL runs as an iterative unsigned shift-add over WIDTH cycles; every other op completes
// in a single cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation present on a/b/op_code/op_ext
//   in_ready   block can accept an operation this cycle
//   a, b       operands (WIDTH bits)
//   op_code    primary opcode (4 bits)
//   op_ext     opcode extension (4 bits)
//   out_valid  result/psr/out_wb/illegal are valid
//   out_ready  consumer takes the output this cycle
//   result     registered result (WIDTH bits)
//   out_wb     result is to be written back
//   psr        {3'b000, C, L, F, Z, N}
//   illegal    undecoded op_code/op_ext, qualified by out_valid

module alu_pipe #(
    parameter int WIDTH      = 16,
    parameter int IMM_WIDTH  = 8,
    parameter int SIMM_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    input  logic [3:0]       op_ext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_wb,
    output logic [7:0]       psr,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ILL,
        OP_ADD,
        OP_SUB,
        OP_CMP,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_MOVB,
        OP_LSH,
        OP_RSH,
        OP_LUI
    } op_sel_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [7:0]        psr_q, psr_d;
    logic              wb_q, wb_d;
    logic              ill_q, ill_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    op_sel_e           op_sel;
    logic              use_sx;
    logic              use_simm;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  shamt_src;
    logic [WIDTH-1:0]  shamt_mag;
    logic              shift_left;
    logic [WIDTH-1:0]  shift_res;
    logic [WIDTH:0]    add_full;
    logic [WIDTH:0]    sub_full;
    logic              add_ovf;
    logic              sub_ovf;
    logic              cmp_lt_s;
    logic [WIDTH-1:0]  alu_res;
    logic [7:0]        alu_psr;
    logic              alu_wb;
    logic              alu_ill;
    logic [WIDTH-1:0]  mul_sum;
    logic              accept;

    // Opcode decode into an operation class plus operand-selection controls.
    always_comb begin
        op_sel   = OP_ILL;
        use_sx   = 1'b0;
        use_simm = 1'b0;
        case (op_code)
            4'h0: begin
                case (op_ext)
                    4'h5:    op_sel = OP_ADD;
                    4'h9:    op_sel = OP_SUB;
                    4'hB:    op_sel = OP_CMP;
                    4'hE:    op_sel = OP_MUL;
                    4'h1:    op_sel = OP_AND;
                    4'h2:    op_sel = OP_OR;
                    4'h3:    op_sel = OP_XOR;
                    4'hD:    op_sel = OP_MOVB;
                    default: op_sel = OP_ILL;
                endcase
            end
            4'h1: op_sel = OP_AND;
            4'h2: op_sel = OP_OR;
            4'h3: op_sel = OP_XOR;
            4'h5: begin
                op_sel = OP_ADD;
                use_sx = 1'b1;
            end
            4'h9: begin
                op_sel = OP_SUB;
                use_sx = 1'b1;
            end
            4'hB: begin
                op_sel = OP_CMP;
                use_sx = 1'b1;
            end
            4'hD: op_sel = OP_MOVB;
            // LOAD/STORE/JAL/JCOND all use ext values 0/4/8/C and compute a + b.
            4'h4: begin
                if (op_ext[1:0] == 2'b00) begin
                    op_sel = OP_ADD;
                end
            end
            4'h8: begin
                case (op_ext)
                    4'h4: op_sel = OP_LSH;
                    4'h0: begin
                        op_sel   = OP_LSH;
                        use_simm = 1'b1;
                    end
                    4'h1: begin
                        op_sel   = OP_RSH;
                        use_simm = 1'b1;
                    end
                    default: op_sel = OP_ILL;
                endcase
            end
            4'hF:    op_sel = OP_LUI;
            default: op_sel = OP_ILL;
        endcase
    end

    // Operand conditioning, adder/subtractor and shifter.
    always_comb begin
        opb = use_sx ? {{(WIDTH-IMM_WIDTH){b[IMM_WIDTH-1]}}, b[IMM_WIDTH-1:0]} : b;

        add_full = {1'b0, a} + {1'b0, opb};
        sub_full = {1'b0, a} - {1'b0, opb};
        add_ovf  = (a[WIDTH-1] == opb[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
        sub_ovf  = (a[WIDTH-1] != opb[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
        cmp_lt_s = $signed(a) < $signed(opb);

        shamt_src = use_simm ? {{(WIDTH-SIMM_WIDTH){b[SIMM_WIDTH-1]}}, b[SIMM_WIDTH-1:0]} : b;
        // Magnitude of the signed shift amount; the most negative value stays huge and
        // therefore falls into the shift-out-to-zero case.
        shamt_mag  = shamt_src[WIDTH-1] ? (-shamt_src) : shamt_src;
        // LSH shifts left for non-negative amounts; RSHI mirrors the direction.
        shift_left = (op_sel == OP_LSH) ? ~shamt_src[WIDTH-1] : shamt_src[WIDTH-1];
        if (shamt_mag >= WIDTH_V) begin
            shift_res = '0;
        end else if (shift_left) begin
            shift_res = a << shamt_mag;
        end else begin
            shift_res = a >> shamt_mag;
        end
    end

    // Single-cycle result, flag update and write-back selection.
    always_comb begin
        alu_res = '0;
        alu_psr = psr_q;
        alu_wb  = 1'b1;
        alu_ill = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_res        = add_full[WIDTH-1:0];
                alu_psr[PSR_C] = add_full[WIDTH];
                alu_psr[PSR_F] = add_ovf;
            end
            OP_SUB: begin
                alu_res        = sub_full[WIDTH-1:0];
                alu_psr[PSR_C] = sub_full[WIDTH];
                alu_psr[PSR_F] = sub_ovf;
            end
            OP_CMP: begin
                alu_wb         = 1'b0;
                alu_psr[PSR_L] = sub_full[WIDTH];
                alu_psr[PSR_N] = cmp_lt_s;
                alu_psr[PSR_Z] = (a == opb);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_MOVB: alu_res = b;
            OP_LSH:  alu_res = shift_res;
            OP_RSH:  alu_res = shift_res;
            OP_LUI:  alu_res = {b[7:0], {(WIDTH-8){1'b0}}};
            OP_MUL:  alu_res = '0;
            default: begin
                alu_wb  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;

    assign result  = result_q;
    assign out_wb  = wb_q;
    assign psr     = psr_q;
    assign illegal = ill_q;

    // Next-state logic: MUL iteration, output consumption, then a new accept which
    // takes priority so a DONE->load happens on the same edge the output is consumed.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        psr_d    = psr_q;
        wb_d     = wb_q;
        ill_d    = ill_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE: ;
            ST_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The last partial product is folded straight into the result register.
                if (cnt_q == CNT_LAST) begin
                    result_d = mul_sum;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (op_sel == OP_MUL) begin
                state_d  = ST_MUL;
                acc_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                cnt_d    = '0;
                result_d = '0;
                wb_d     = 1'b1;
                ill_d    = 1'b0;
            end else begin
                state_d  = ST_DONE;
                result_d = alu_res;
                psr_d    = alu_psr;
                wb_d     = alu_wb;
                ill_d    = alu_ill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            psr_q    <= '0;
            wb_q     <= 1'b0;
            ill_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            psr_q    <= psr_d;
            wb_q     <= wb_d;
            ill_q    <= ill_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking scoreboard bench for alu_pipe (WIDTH=16)

module tb_alu_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op_code;
    logic [3:0]   op_ext;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         out_wb;
    logic [7:0]   psr;
    logic         illegal;

    typedef struct packed {
        logic [15:0] res;
        logic        wb;
        logic        ill;
        logic [7:0]  psr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_psr;
    int         n_cmp;
    int         n_bad;

    logic [7:0] legal_ops [16] = '{8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h10,
                                   8'h20, 8'h30, 8'h50, 8'h90, 8'hB0, 8'hD0, 8'h44, 8'hF0};

    alu_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_code   (op_code),
        .op_ext    (op_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_wb    (out_wb),
        .psr       (psr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic, psr bits {C,L,F,Z,N} = [4:0].
    function automatic exp_t model(input logic [3:0] oc, input logic [3:0] oe,
                                   input logic [15:0] av, input logic [15:0] bv);
        exp_t        e;
        logic [15:0] x;
        longint      r;
        int          sav;
        int          sx;
        int          s;
        int          sh;
        int          k;
        e.res = 16'h0000;
        e.wb  = 1'b1;
        e.ill = 1'b0;
        e.psr = m_psr;
        x     = bv;
        k     = 0;
        casez ({oc, oe})
            8'h05, 8'h40, 8'h44, 8'h48, 8'h4C: k = 1;
            8'h5?: begin k = 1; x = {{8{bv[7]}}, bv[7:0]}; end
            8'h09: k = 2;
            8'h9?: begin k = 2; x = {{8{bv[7]}}, bv[7:0]}; end
            8'h0B: k = 3;
            8'hB?: begin k = 3; x = {{8{bv[7]}}, bv[7:0]}; end
            8'h0E: k = 4;
            8'h01, 8'h1?: k = 5;
            8'h02, 8'h2?: k = 6;
            8'h03, 8'h3?: k = 7;
            8'h0D, 8'hD?: k = 8;
            8'h84: k = 9;
            8'h80: k = 10;
            8'h81: k = 11;
            8'hF?: k = 12;
            default: k = 0;
        endcase
        sav = $signed(av);
        sx  = $signed(x);
        case (k)
            1: begin
                r = longint'(av) + longint'(x);
                e.res    = 16'(r);
                e.psr[4] = (r > 65535);
                s = sav + sx;
                e.psr[2] = (s > 32767) || (s < -32768);
            end
            2: begin
                e.res    = av - x;
                e.psr[4] = (av < x);
                s = sav - sx;
                e.psr[2] = (s > 32767) || (s < -32768);
            end
            3: begin
                e.wb     = 1'b0;
                e.psr[3] = (av < x);
                e.psr[0] = (sav < sx);
                e.psr[1] = (av == x);
            end
            4: begin
                r = longint'(av) * longint'(bv);
                e.res = 16'(r);
            end
            5: e.res = av & bv;
            6: e.res = av | bv;
            7: e.res = av ^ bv;
            8: e.res = bv;
            9, 10, 11: begin
                if (k == 9)       sh = $signed(bv);
                else if (k == 10) sh = int'($signed(bv[3:0]));
                else              sh = -int'($signed(bv[3:0]));
                if (sh >= 16 || sh <= -16) e.res = 16'h0000;
                else if (sh >= 0)          e.res = av << sh;
                else                       e.res = av >> (-sh);
            end
            12: e.res = {bv[7:0], 8'h00};
            default: begin
                e.wb  = 1'b0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Drive one op at the current (negedge) time; it is accepted at the next posedge.
    task automatic issue(input logic [3:0] oc, input logic [3:0] oe,
                         input logic [15:0] av, input logic [15:0] bv);
        exp_t e;
        e = model(oc, oe, av, bv);
        m_psr = e.psr;
        sb.push_back(e);
        op_code  = oc;
        op_ext   = oe;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Issue an op and wait (bounded) for out_valid; returns the observed output,
    // the latency in cycles after the accept edge, and whether in_ready rose while busy.
    task automatic run_one(input logic [3:0] oc, input logic [3:0] oe,
                           input logic [15:0] av, input logic [15:0] bv,
                           output exp_t got, output int lat, output bit rdy_busy);
        issue(oc, oe, av, bv);
        lat      = 0;
        rdy_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_busy = 1'b1;
        end while (!out_valid && lat < 40);
        got = {result, out_wb, illegal, psr};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_psr = 8'h00;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        repeat (3) @(negedge clk);
        obs = {out_valid, in_ready, result, out_wb, illegal, psr, 1'b0};
        n_cmp++;
        if (obs !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", obs,
                     {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0});
        end
        rst_n = 1'b1;
        m_psr = 8'h00;
    endtask

    task automatic test_add();
        exp_t got;
        exp_t exp;
        int   lat;
        bit   busy;
        out_ready = 1'b1;
        @(negedge clk);
        run_one(4'h0, 4'h5, 16'h7FFF, 16'h0001, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL add_overflow: got %h expected %h", got, exp);
        end
        n_cmp++;
        if (lat != 1) begin
            n_bad++;
            $display("FAIL add_latency: got %0d expected 1", lat);
        end
        run_one(4'h5, 4'h0, 16'h0005, 16'h00FF, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL addi_sext: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_cmp();
        exp_t got;
        exp_t exp;
        int   lat;
        bit   busy;
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        run_one(4'h0, 4'hB, 16'h0001, 16'hFFFF, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL cmp: got %h expected %h", got, exp);
        end
        run_one(4'hB, 4'h0, 16'hFFFF, 16'h00FF, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL cmpi: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_mul();
        exp_t got;
        exp_t exp;
        int   lat;
        bit   busy;
        out_ready = 1'b1;
        @(negedge clk);
        run_one(4'h0, 4'hE, 16'h0123, 16'h0100, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL mul_result: got %h expected %h", got, exp);
        end
        n_cmp++;
        if (lat != 17) begin
            n_bad++;
            $display("FAIL mul_latency: got %0d expected 17", lat);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_in_ready: got %0d expected 0", busy);
        end
        run_one(4'h0, 4'hE, 16'hBEEF, 16'hCAFE, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL mul_wide: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_shift();
        logic [47:0] vec [5] = '{{8'h84, 16'h00F0, 16'hFFFC}, {8'h80, 16'h00F0, 16'h000C},
                                 {8'h81, 16'h00F0, 16'h0002}, {8'h84, 16'h00F0, 16'h0010},
                                 {8'h81, 16'h8001, 16'h000F}};
        logic [47:0] v;
        exp_t got;
        exp_t exp;
        int   lat;
        bit   busy;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            v = vec[i];
            run_one(v[39:36], v[35:32], v[31:16], v[15:0], got, lat, busy);
            exp = sb.pop_front();
            n_cmp++;
            if (!out_valid || got !== exp) begin
                n_bad++;
                $display("FAIL shift_%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random_ops();
        logic [7:0] code;
        exp_t got;
        exp_t exp;
        int   lat;
        bit   busy;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            code = legal_ops[$urandom_range(15)];
            run_one(code[7:4], code[3:0], 16'($urandom), 16'($urandom), got, lat, busy);
            exp = sb.pop_front();
            n_cmp++;
            if (!out_valid || got !== exp) begin
                n_bad++;
                $display("FAIL rand_op_%h: got %h expected %h", code, got, exp);
            end
        end
    endtask

    task automatic test_hold();
        exp_t        got;
        exp_t        exp;
        int          lat;
        bit          busy;
        logic [27:0] obs;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_one(4'h0, 4'h5, 16'h1234, 16'hF00D, got, lat, busy);
        exp = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {out_valid, in_ready, result, out_wb, illegal, psr};
            n_cmp++;
            if (obs !== {1'b1, 1'b0, exp}) begin
                n_bad++;
                $display("FAIL hold_cycle_%0d: got %h expected %h", i, obs, {1'b1, 1'b0, exp});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_release: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t exp;
        exp_t got;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            e = model(4'h0, 4'h5, 16'(16'h3000 * i), 16'(16'h2FFF + i));
            m_psr = e.psr;
            sb.push_back(e);
            op_code  = 4'h0;
            op_ext   = 4'h5;
            a        = 16'(16'h3000 * i);
            b        = 16'(16'h2FFF + i);
            in_valid = 1'b1;
            @(negedge clk);
            exp = sb.pop_front();
            got = {result, out_wb, illegal, psr};
            n_cmp++;
            if (!out_valid || got !== exp) begin
                n_bad++;
                $display("FAIL b2b_%0d: valid %b got %h expected %h", i, out_valid, got, exp);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        logic [7:0] codes [5] = '{8'h60, 8'h00, 8'h41, 8'h82, 8'hE7};
        logic [7:0] code;
        exp_t got;
        exp_t exp;
        int   lat;
        bit   busy;
        out_ready = 1'b1;
        @(negedge clk);
        run_one(4'h0, 4'h9, 16'h8000, 16'h0001, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL sub_pre_illegal: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 5; i++) begin
            code = codes[i];
            run_one(code[7:4], code[3:0], 16'hABCD, 16'h1357, got, lat, busy);
            exp = sb.pop_front();
            n_cmp++;
            if (!out_valid || got !== exp || lat != 1) begin
                n_bad++;
                $display("FAIL illegal_%h: got %h lat %0d expected %h lat 1", code, got, lat, exp);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t        got;
        exp_t        exp;
        int          lat;
        bit          busy;
        bit          stray;
        logic [27:0] obs;
        out_ready = 1'b1;
        @(negedge clk);
        run_one(4'h0, 4'h5, 16'h7FFF, 16'h0001, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp) begin
            n_bad++;
            $display("FAIL pre_mul_add: got %h expected %h", got, exp);
        end
        issue(4'h0, 4'hE, 16'h1234, 16'h0056);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        obs = {out_valid, in_ready, result, out_wb, illegal, psr};
        n_cmp++;
        if (obs !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", obs,
                     {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00});
        end
        sb.delete();
        m_psr = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_bad++;
            $display("FAIL aborted_mul_output: got %0d expected 0", stray);
        end
        run_one(4'h0, 4'h5, 16'h1234, 16'h1111, got, lat, busy);
        exp = sb.pop_front();
        n_cmp++;
        if (!out_valid || got !== exp || lat != 1) begin
            n_bad++;
            $display("FAIL post_reset_add: got %h lat %0d expected %h lat 1", got, lat, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        m_psr     = 8'h00;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op_code   = 4'h0;
        op_ext    = 4'h0;
        test_reset();
        test_add();
        test_cmp();
        test_mul();
        test_shift();
        test_random_ops();
        test_hold();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mul();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
